fp_arbiter: RTL and testbench
=============================

Name: fp_arbiter

Overview:
- Shares one fp_unit between NREQ independent requesters (e.g. integer core issue port, vector sequencer, debug port).
- Round-robin arbitration; exactly one operation in flight at a time.
- Drives the fp_exe input fields and the one-cycle enable strobe, waits for fp_unit ready, and returns result/flags to the granted requester with a tag.
- A watchdog bounds wait time on the variable-latency div/sqrt paths.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 3, width of requester index on rsp_id; must satisfy 2^IDW >= NREQ.
- TIMEOUT, 255, maximum cycles spent in WAIT before an error response is returned; 0 disables the watchdog.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_op  in  NREQ x 209  fp_arb_req_type per requester: data1/data2/data3 64 each, fmt 2, rm 3, opcode 10 (one-hot: fmadd, fadd, fsub, fmul, fdiv, fsqrt, fcmp, fcvt_f2f, fcvt_i2f, fcvt_f2i, bit0..bit9), fcvt_op 2
- fpu_op  out  209  latched operation driven to the fp_unit input fields
- fpu_enable  out  1  one-cycle issue strobe
- fpu_result  in  64  fp_unit result
- fpu_flags  in  5  fp_unit exception flags (NV DZ OF UF NX)
- fpu_ready  in  1  fp_unit completion
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the requester being answered
- rsp_result  out  64  captured result
- rsp_flags  out  5  captured flags
- rsp_err  out  1  watchdog expired; result and flags are 0

Behaviour:
- Reset (reset==0 at a clock edge) values:
  - state=IDLE, rr_ptr=0, wdog=0.
  - fpu_op=0, fpu_enable=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0.
  - req_ready=0 while reset is low.
  - Reset mid-operation abandons the in-flight op; no response is produced, and any later fpu_ready is ignored.
- State IDLE:
  - req_ready is combinational: one-hot on the first valid requester searching from rr_ptr upward, modulo NREQ; all-zero if none valid.
  - On grant: latch req_op[g] into fpu_op, latch g into rsp_id, set rr_ptr=(g+1) mod NREQ, go to ISSUE.
- State ISSUE:
  - fpu_enable=1 for exactly this cycle; fpu_op is held stable.
  - Clear wdog; go to WAIT.
- State WAIT:
  - fpu_enable=0 and fpu_op held.
  - If fpu_ready: capture fpu_result into rsp_result and fpu_flags into rsp_flags, set rsp_err=0, go to RESP.
  - Else if TIMEOUT!=0 and wdog==TIMEOUT: set rsp_result=0, rsp_flags=0, rsp_err=1, go to RESP.
  - Else wdog+=1 (8-bit saturating register, widened to cover TIMEOUT).
- State RESP:
  - rsp_valid=1; rsp_id, rsp_result, rsp_flags and rsp_err are held stable until the handshake.
  - On rsp_ready: go to IDLE next cycle. No new grant is made in the handshake cycle.
- fpu_ready is sampled only in WAIT; it is ignored in IDLE, ISSUE and RESP, so a ready in the enable cycle is not taken.
- Minimum latency, grant to rsp_valid: 3 cycles (grant, ISSUE, WAIT with ready). Back-to-back throughput is one op per 4+ cycles.
- A requester whose req_valid drops before grant is simply not granted; requests are not queued.
- rr_ptr changes only on grant.

Decomposition:
- Package fp_arb_wire, next to fp_wire, holds:
  - fp_arb_req_type (packed struct, field order as listed under req_op);
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - opcode bit-position constants.
- Sub-module fp_rr_arbiter (NREQ): inputs req, ptr; output one-hot grant and encoded index. Purely combinational; the pointer register stays in fp_arbiter.
- fp_arbiter instantiates fp_rr_arbiter. The top-level wrapper maps fpu_op onto fp_unit_in_type.fp_exe_i: unused op bits (fmsub, fnmadd, fnmsub, fsgnj, fmax, fclass, fmv_i2f, fmv_f2i) tied to 0.

Test Plan:
- Single fadd on req0 (data1=0x3F800000, data2=0x40000000, fmt=0, rm=0); model completes 2 cycles after enable with 0x40400000, flags 0.
  - Required: fpu_enable high exactly 1 cycle; rsp_valid 4 cycles after grant with rsp_id=0, result 0x40400000, flags 00000.
- req0 and req1 both valid continuously, 4 ops each.
  - Required grant order 0,1,0,1,...; rr_ptr alternates; no requester granted twice in a row.
- fdiv with model ready withheld and TIMEOUT=15.
  - Required: rsp_valid after exactly 16 WAIT cycles, rsp_err=1, result 0, flags 0. A later stray fpu_ready in IDLE produces no response.
- Response backpressure: hold rsp_ready=0 for 10 cycles with req1 valid.
  - Required: rsp fields stable; req_ready stays 0; req1 is granted the cycle after the rsp handshake.
- Reset driven low during WAIT of an fsqrt, then released.
  - Required: all outputs 0 the next cycle; the model's later ready is ignored; the next request gets a normal response.
- fpu_ready asserted in the same cycle as fpu_enable, then deasserted.
  - Required: arbiter stays in WAIT until the next ready; no response is taken from the early pulse.

Source files
------------

// File: rtl/fp_arbiter_pkg.sv
// fp_arb_wire: shared types for the fp_unit arbiter.
//   fp_arb_req_type    - one requester's operation (209 bits, data1 in the MSBs)
//   fp_arb_state_type  - arbiter FSM states
//   OP_*               - bit positions inside the one-hot opcode field
package fp_arb_wire;

    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [63:0] data3;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [9:0]  opcode;
        logic [1:0]  fcvt_op;
    } fp_arb_req_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fp_arb_state_type;

    localparam int OP_FMADD    = 0;
    localparam int OP_FADD     = 1;
    localparam int OP_FSUB     = 2;
    localparam int OP_FMUL     = 3;
    localparam int OP_FDIV     = 4;
    localparam int OP_FSQRT    = 5;
    localparam int OP_FCMP     = 6;
    localparam int OP_FCVT_F2F = 7;
    localparam int OP_FCVT_I2F = 8;
    localparam int OP_FCVT_F2I = 9;

endpackage

// File: rtl/fp_arbiter_rr_arbiter.sv
// fp_rr_arbiter: combinational round-robin pick.
//   req   [NREQ] - request vector
//   ptr   [IDW]  - requester with highest priority this cycle (< NREQ)
//   grant [NREQ] - one-hot grant, zero when no request
//   index [IDW]  - encoded grant index (0 when no request)
module fp_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  index
);

    logic [IDW:0] pos;
    logic         found;

    // Walk positions ptr, ptr+1, ... wrapping at NREQ; the inner loop keeps
    // every vector index a constant so no index is wider than its target.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NREQ)) begin
                pos = pos - (IDW+1)'(NREQ);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!found && pos == (IDW+1)'(i) && req[i]) begin
                    grant[i] = 1'b1;
                    index    = IDW'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fp_arbiter.sv
// fp_arbiter: shares one fp_unit between NREQ requesters, one op in flight.
//   clock, reset          - clock, synchronous active-low reset
//   req_valid/req_ready   - per-requester request handshake; req_ready is a
//                           combinational one-hot grant, only offered in IDLE
//   req_op                - per-requester operation
//   fpu_op, fpu_enable    - latched operation and one-cycle issue strobe
//   fpu_result/flags/ready- fp_unit completion, sampled only while waiting
//   rsp_*                 - response to the granted requester, tagged by rsp_id;
//                           rsp_err marks a watchdog expiry (result/flags 0)
//   debug_state, debug_rr_ptr - FSM state and round-robin pointer
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high. rsp_* are held stable from rsp_valid rising until that edge.
//
// Downstream, fpu_op maps onto fp_unit_in_type.fp_exe_i; the fp_exe op bits
// this block does not drive (fmsub, fnmadd, fnmsub, fsgnj, fmax, fclass,
// fmv_i2f, fmv_f2i) are tied to 0 there. IDW must satisfy 2**IDW >= NREQ.
module fp_arbiter
    import fp_arb_wire::*;
#(
    parameter int NREQ    = 2,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  fp_arb_req_type [NREQ-1:0]   req_op,
    output fp_arb_req_type              fpu_op,
    output logic                        fpu_enable,
    input  logic [63:0]                 fpu_result,
    input  logic [4:0]                  fpu_flags,
    input  logic                        fpu_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic [63:0]                 rsp_result,
    output logic [4:0]                  rsp_flags,
    output logic                        rsp_err,
    output fp_arb_state_type            debug_state,
    output logic [IDW-1:0]              debug_rr_ptr
);

    // Watchdog is at least 8 bits, wider if TIMEOUT needs it.
    localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    fp_arb_state_type state;
    logic [IDW-1:0]   rr_ptr;
    logic [WDW-1:0]   wdog;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    fp_arb_req_type   grant_op;

    fp_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (grant_idx)
    );

    // Grant is only offered in IDLE and never while reset is asserted.
    assign req_ready = (reset && state == IDLE) ? grant : '0;

    // One-hot select of the granted requester's operation.
    always_comb begin
        grant_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_op = req_op[i];
            end
        end
    end

    assign debug_state  = state;
    assign debug_rr_ptr = rr_ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            wdog       <= '0;
            fpu_op     <= '0;
            fpu_enable <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            fpu_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        fpu_op     <= grant_op;
                        rsp_id     <= grant_idx;
                        rr_ptr     <= (grant_idx == IDW'(NREQ - 1)) ? '0
                                                                    : grant_idx + IDW'(1);
                        fpu_enable <= 1'b1;  // high for the whole ISSUE cycle
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (fpu_ready) begin
                        rsp_result <= fpu_result;
                        rsp_flags  <= fpu_flags;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (TIMEOUT != 0 && wdog == WDW'(TIMEOUT)) begin
                        rsp_result <= '0;
                        rsp_flags  <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (wdog != '1) begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_arbiter.sv
module tb_fp_arbiter;
    import fp_arb_wire::*;

    localparam int NREQ    = 2;
    localparam int IDW     = 3;
    localparam int TIMEOUT = 15;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [NREQ-1:0]            req_valid = '0;
    logic [NREQ-1:0]            req_ready;
    fp_arb_req_type [NREQ-1:0]  req_op = '0;
    fp_arb_req_type             fpu_op;
    logic                       fpu_enable;
    logic [63:0]                fpu_result = '0;
    logic [4:0]                 fpu_flags = '0;
    logic                       fpu_ready = 1'b0;
    logic                       rsp_valid;
    logic                       rsp_ready = 1'b0;
    logic [IDW-1:0]             rsp_id;
    logic [63:0]                rsp_result;
    logic [4:0]                 rsp_flags;
    logic                       rsp_err;
    fp_arb_state_type           debug_state;
    logic [IDW-1:0]             debug_rr_ptr;

    fp_arbiter #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .fpu_op       (fpu_op),
        .fpu_enable   (fpu_enable),
        .fpu_result   (fpu_result),
        .fpu_flags    (fpu_flags),
        .fpu_ready    (fpu_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_err      (rsp_err),
        .debug_state  (debug_state),
        .debug_rr_ptr (debug_rr_ptr)
    );

    // scoreboard counters
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic fp_arb_req_type mk_op(input logic [63:0] d1, input logic [63:0] d2,
                                             input int op_bit);
        fp_arb_req_type r;
        r         = '0;
        r.data1   = d1;
        r.data2   = d2;
        r.data3   = 64'h0;
        r.fmt     = 2'd0;
        r.rm      = 3'd0;
        r.opcode  = 10'd0;
        r.opcode[op_bit] = 1'b1;
        return r;
    endfunction

    // Called in IDLE with req_valid already set; returns at the ISSUE cycle.
    task automatic grant_and_issue(input int exp_g, input bit drop_valid);
        logic [NREQ-1:0] exp_grant;
        exp_grant = '0;
        exp_grant[exp_g] = 1'b1;
        #1;
        check("grant", req_ready, exp_grant);
        step();
        if (drop_valid) req_valid = '0;
        #1;
        check("issue_enable", fpu_enable, 1'b1);
        check("issue_op", fpu_op, req_op[exp_g]);
        check("issue_state", debug_state, ISSUE);
        check("rr_ptr", debug_rr_ptr, IDW'((exp_g + 1) % NREQ));
        check("issue_no_grant", req_ready, '0);
    endtask

    // From ISSUE: fp_unit answers lat cycles after the enable cycle; returns in RESP.
    task automatic wait_ready(input int exp_id, input int lat, input logic [63:0] res,
                              input logic [4:0] flg);
        step();
        check("wait_enable_low", fpu_enable, 1'b0);
        for (int k = 1; k < lat; k++) step();
        fpu_ready  = 1'b1;
        fpu_result = res;
        fpu_flags  = flg;
        step();
        fpu_ready  = 1'b0;
        fpu_result = 64'hBAD0_BAD0_BAD0_BAD0;
        fpu_flags  = 5'b11111;
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_id", rsp_id, IDW'(exp_id));
        check("rsp_result", rsp_result, res);
        check("rsp_flags", rsp_flags, flg);
        check("rsp_err", rsp_err, 1'b0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        #1;
        check("resp_no_grant", req_ready, '0);
        step();
        rsp_ready = 1'b0;
        check("rsp_valid_clear", rsp_valid, 1'b0);
        check("back_idle", debug_state, IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        // reset state, with requests present to prove req_ready is gated
        req_valid = 2'b11;
        step();
        step();
        check("rst_req_ready", req_ready, '0);
        check("rst_fpu_op", fpu_op, '0);
        check("rst_fpu_enable", fpu_enable, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, '0);
        check("rst_rsp_result", rsp_result, '0);
        check("rst_rsp_flags", rsp_flags, '0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_state", debug_state, IDLE);
        check("rst_rr_ptr", debug_rr_ptr, '0);
        req_valid = '0;
        reset = 1'b1;
        step();

        // single fadd 1.0 + 2.0 = 3.0 on req0, answer 2 cycles after enable
        req_op[0] = mk_op(64'h3F80_0000, 64'h4000_0000, OP_FADD);
        req_valid = 2'b01;
        grant_and_issue(0, 1'b1);
        wait_ready(0, 2, 64'h4040_0000, 5'b00000);
        handshake();

        // both requesters continuously valid; rr_ptr is 1 after the fadd
        req_op[0] = mk_op(64'h1111, 64'h2222, OP_FMUL);
        req_op[1] = mk_op(64'h3333, 64'h4444, OP_FSUB);
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            grant_and_issue((k + 1) % 2, k == 7);
            wait_ready((k + 1) % 2, 1 + k % 3, 64'h1000 + 64'(k), 5'(k));
            handshake();
        end

        // fdiv on req1 that never completes: watchdog fires after 16 WAIT cycles
        req_op[1] = mk_op(64'h4000_0000, 64'h0, OP_FDIV);
        req_valid = 2'b10;
        grant_and_issue(1, 1'b1);
        step();
        cnt = 0;
        while (debug_state == WAIT && cnt < 100) begin
            cnt++;
            step();
        end
        check("timeout_cycles", 256'(cnt), 256'(16));
        check("timeout_valid", rsp_valid, 1'b1);
        check("timeout_err", rsp_err, 1'b1);
        check("timeout_result", rsp_result, '0);
        check("timeout_flags", rsp_flags, '0);
        check("timeout_id", rsp_id, IDW'(1));
        handshake();
        fpu_ready = 1'b1;
        step();
        step();
        fpu_ready = 1'b0;
        check("stray_ready_no_rsp", rsp_valid, 1'b0);
        check("stray_ready_idle", debug_state, IDLE);

        // response backpressure with req1 waiting
        req_op[0] = mk_op(64'h3FF0_0000_0000_0000, 64'h1, OP_FCMP);
        req_valid = 2'b01;
        grant_and_issue(0, 1'b1);
        wait_ready(0, 1, 64'h0000_0000_0000_0001, 5'b10000);
        req_valid = 2'b10;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_id", rsp_id, IDW'(0));
            check("bp_result", rsp_result, 64'h1);
            check("bp_flags", rsp_flags, 5'b10000);
            check("bp_req_ready", req_ready, '0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_released", rsp_valid, 1'b0);
        grant_and_issue(1, 1'b1);
        wait_ready(1, 3, 64'hC000_0000_0000_0000, 5'b00100);
        handshake();

        // reset during WAIT of an fsqrt, later fp_unit ready is ignored
        req_op[0] = mk_op(64'h4010_0000_0000_0000, 64'h0, OP_FSQRT);
        req_valid = 2'b01;
        grant_and_issue(0, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();
        check("mid_rst_req_ready", req_ready, '0);
        check("mid_rst_fpu_op", fpu_op, '0);
        check("mid_rst_enable", fpu_enable, 1'b0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_rsp_result", rsp_result, '0);
        check("mid_rst_state", debug_state, IDLE);
        check("mid_rst_rr_ptr", debug_rr_ptr, '0);
        req_valid = '0;
        reset = 1'b1;
        fpu_ready  = 1'b1;
        fpu_result = 64'h4000_0000_0000_0000;
        step();
        fpu_ready = 1'b0;
        check("late_ready_ignored", rsp_valid, 1'b0);
        step();
        check("late_ready_idle", debug_state, IDLE);
        req_op[1] = mk_op(64'h5, 64'h6, OP_FCVT_I2F);
        req_valid = 2'b10;
        grant_and_issue(1, 1'b1);
        wait_ready(1, 1, 64'h4014_0000_0000_0000, 5'b00001);
        handshake();

        // fpu_ready pulse in the enable cycle must not be taken
        req_op[0] = mk_op(64'h4000_0000, 64'h4040_0000, OP_FMUL);
        req_valid = 2'b01;
        grant_and_issue(0, 1'b1);
        fpu_ready  = 1'b1;
        fpu_result = 64'hDEAD;
        step();
        fpu_ready = 1'b0;
        check("early_ready_state", debug_state, WAIT);
        check("early_ready_no_rsp", rsp_valid, 1'b0);
        step();
        step();
        check("early_ready_still_wait", debug_state, WAIT);
        check("early_ready_still_no_rsp", rsp_valid, 1'b0);
        fpu_ready  = 1'b1;
        fpu_result = 64'h40C0_0000;
        fpu_flags  = 5'b00000;
        step();
        fpu_ready = 1'b0;
        check("early_rsp_valid", rsp_valid, 1'b1);
        check("early_rsp_result", rsp_result, 64'h40C0_0000);
        check("early_rsp_id", rsp_id, IDW'(0));
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
